// File: rtl/word_to_number_if.sv
// Character-in / number-out handshake bundle for word_to_number.
// The slave modport is the parser side; the master modport is the
// producer/consumer side that drives characters and takes results.
interface word_to_number_if #(
   parameter int DATA = 32
);
   logic            i_abort;
   logic            i_valid;
   logic [7:0]      i_char;
   logic            i_last;
   logic            o_ready;
   logic            o_valid;
   logic            i_ready;
   logic [DATA-1:0] o_data;
   logic            o_err;

   modport master (
      output i_abort, i_valid, i_char, i_last, i_ready,
      input  o_ready, o_valid, o_data, o_err
   );

   modport slave (
      input  i_abort, i_valid, i_char, i_last, i_ready,
      output o_ready, o_valid, o_data, o_err
   );
endinterface

// File: rtl/word_to_number.sv
// ASCII word parser: consumes one character per beat and produces the
// signed two's-complement value of a decimal, 0x-hex or 0b-binary word,
// or an error flag for malformed, overflowing or over-long words.
module word_to_number #(
   parameter int DATA      = 32,
   parameter int MAX_LEN   = 32,
   parameter int DEF_RADIX = 10
) (
   input logic             i_clk,
   input logic             i_rst_n,
   word_to_number_if.slave bus
);

   localparam int AW = DATA + 4;
   localparam int CW = $clog2(MAX_LEN + 2);

   localparam logic [AW:0]    ONE     = (AW+1)'(1);
   localparam logic [AW:0]    LIM_POS = (ONE << DATA) - ONE;
   localparam logic [AW:0]    LIM_NEG = ONE << (DATA - 1);
   localparam logic [4:0]     DEF_R   = 5'(DEF_RADIX);
   localparam logic [CW-1:0]  CNT_SAT = CW'(MAX_LEN + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_LEN);

   typedef enum logic [2:0] {START, SIGN, ZERO, DIGITS, SKIP, DONE} state_t;

   state_t          state_q, state_nx;
   logic [AW-1:0]   acc_q, acc_nx;
   logic            neg_q, neg_nx;
   logic [4:0]      radix_q, radix_nx;
   logic            have_q, have_nx;   // at least one digit seen after any prefix
   logic            bad_q, bad_nx;     // invalid character seen
   logic            ovf_q, ovf_nx;
   logic            len_q, len_nx;
   logic [CW-1:0]   cnt_q, cnt_nx;

   logic            beat;
   logic [4:0]      d;
   logic [AW:0]     lim;
   logic [AW:0]     sum;
   logic [DATA-1:0] mag;

   // Digit value of an ASCII character; 31 marks a non-digit.
   function automatic logic [4:0] digit_val(input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39) return 5'(c - 8'h30);
      if (c >= 8'h41 && c <= 8'h46) return 5'(c - 8'h37);
      if (c >= 8'h61 && c <= 8'h66) return 5'(c - 8'h57);
      return 5'd31;
   endfunction

   // Multiply by the radix with shifts only; x10 is x8 + x2.
   function automatic logic [AW:0] mul_radix(input logic [AW-1:0] a, input logic [4:0] r);
      logic [AW:0] x;
      x = {1'b0, a};
      case (r)
         5'd2:    return x << 1;
         5'd16:   return x << 4;
         default: return (x << 3) + (x << 1);
      endcase
   endfunction

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= START;
      else          state_q <= state_nx;
   end

   // Word datapath registers: accumulator, sign, radix and sticky error flags.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_q   <= '0;
         neg_q   <= 1'b0;
         radix_q <= DEF_R;
         have_q  <= 1'b0;
         bad_q   <= 1'b0;
         ovf_q   <= 1'b0;
         len_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         acc_q   <= acc_nx;
         neg_q   <= neg_nx;
         radix_q <= radix_nx;
         have_q  <= have_nx;
         bad_q   <= bad_nx;
         ovf_q   <= ovf_nx;
         len_q   <= len_nx;
         cnt_q   <= cnt_nx;
      end
   end

   // Next state and next datapath values for the current character.
   always_comb begin
      state_nx = state_q;
      acc_nx   = acc_q;
      neg_nx   = neg_q;
      radix_nx = radix_q;
      have_nx  = have_q;
      bad_nx   = bad_q;
      ovf_nx   = ovf_q;
      len_nx   = len_q;
      cnt_nx   = cnt_q;
      beat     = bus.i_valid && (state_q != DONE);
      d        = digit_val(bus.i_char);
      lim      = neg_q ? LIM_NEG : LIM_POS;
      sum      = mul_radix(acc_q, radix_q) + (AW+1)'(d);

      // Abort wins over everything; a taken result also restarts the parser.
      if (bus.i_abort || (state_q == DONE && bus.i_ready)) begin
         state_nx = START;
         acc_nx   = '0;
         neg_nx   = 1'b0;
         radix_nx = DEF_R;
         have_nx  = 1'b0;
         bad_nx   = 1'b0;
         ovf_nx   = 1'b0;
         len_nx   = 1'b0;
         cnt_nx   = '0;
      end else if (beat) begin
         cnt_nx = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
         if (cnt_nx > CNT_MAX) len_nx = 1'b1;
         case (state_q)
            START: begin
               if (bus.i_char == 8'h2D) begin
                  neg_nx   = 1'b1;
                  state_nx = SIGN;
               end else if (bus.i_char == 8'h30) begin
                  have_nx  = 1'b1;
                  state_nx = ZERO;
               end else if (d < DEF_R) begin
                  acc_nx   = AW'(d);
                  have_nx  = 1'b1;
                  state_nx = DIGITS;
               end else begin
                  bad_nx   = 1'b1;
                  state_nx = SKIP;
               end
            end
            SIGN: begin
               if (bus.i_char == 8'h30) begin
                  have_nx  = 1'b1;
                  state_nx = ZERO;
               end else if (d < DEF_R) begin
                  acc_nx   = AW'(d);
                  have_nx  = 1'b1;
                  state_nx = DIGITS;
               end else begin
                  bad_nx   = 1'b1;
                  state_nx = SKIP;
               end
            end
            ZERO: begin
               // A prefix invalidates the lone '0' as the number's digit.
               if (bus.i_char == 8'h78 || bus.i_char == 8'h58) begin
                  radix_nx = 5'd16;
                  have_nx  = 1'b0;
                  state_nx = DIGITS;
               end else if (bus.i_char == 8'h62 || bus.i_char == 8'h42) begin
                  radix_nx = 5'd2;
                  have_nx  = 1'b0;
                  state_nx = DIGITS;
               end else if (d < DEF_R) begin
                  acc_nx   = AW'(d);
                  state_nx = DIGITS;
               end else begin
                  bad_nx   = 1'b1;
                  state_nx = SKIP;
               end
            end
            DIGITS: begin
               if (d < radix_q) begin
                  have_nx = 1'b1;
                  // Once overflowed the accumulator stays pinned at the limit.
                  if (!ovf_q) begin
                     if (sum > lim) begin
                        ovf_nx = 1'b1;
                        acc_nx = lim[AW-1:0];
                     end else begin
                        acc_nx = sum[AW-1:0];
                     end
                  end
               end else begin
                  bad_nx   = 1'b1;
                  state_nx = SKIP;
               end
            end
            default: ;
         endcase
         if (bus.i_last) state_nx = DONE;
      end
   end

   // Result presentation: value only when the word parsed cleanly.
   always_comb begin
      bus.o_valid = 1'b0;
      bus.o_ready = 1'b1;
      bus.o_data  = '0;
      bus.o_err   = 1'b0;
      mag         = acc_q[DATA-1:0];
      if (state_q == DONE) begin
         bus.o_valid = 1'b1;
         bus.o_ready = 1'b0;
         if (bad_q || ovf_q || len_q || !have_q) begin
            bus.o_err = 1'b1;
         end else begin
            bus.o_data = neg_q ? -mag : mag;
         end
      end
   end

endmodule

// File: tb/tb_word_to_number.sv
// Randomised bench for word_to_number with a string-level reference parser.
module tb_word_to_number;

   localparam int DATA    = 32;
   localparam int MAX_LEN = 32;
   localparam int DEF     = 10;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   word_to_number_if #(.DATA(DATA)) bus ();

   word_to_number #(.DATA(DATA), .MAX_LEN(MAX_LEN), .DEF_RADIX(DEF)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int hold_cnt = 0;
   bit chk_en = 0;
   logic [32:0] exp_q[$];   // {err, data}

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int dig(input byte unsigned c);
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "a" && c <= "f") return int'(c) - 87;
      if (c >= "A" && c <= "F") return int'(c) - 55;
      return 99;
   endfunction

   // Reference parser working on the whole word at once.
   function automatic void model(input string s, output logic err, output logic [31:0] val);
      int n = s.len();
      int i = 0;
      int radix = DEF;
      int nd = 0;
      bit neg = 0, bad = 0, ovf = 0;
      longint unsigned m = 0;
      longint unsigned lim;
      byte unsigned c, c1;
      logic [31:0] lo;
      if (n > 0 && s[0] == "-") begin neg = 1; i = 1; end
      lim = neg ? 64'd2147483648 : 64'd4294967295;
      if (i + 1 < n && s[i] == "0") begin
         c1 = s[i+1];
         if (c1 == "x" || c1 == "X") begin radix = 16; i += 2; end
         else if (c1 == "b" || c1 == "B") begin radix = 2; i += 2; end
      end
      for (int k = i; k < n; k++) begin
         c = s[k];
         if (dig(c) >= radix) bad = 1;
         else begin
            nd++;
            m = m * longint'(radix) + longint'(dig(c));
            if (m > lim) begin ovf = 1; m = lim + 1; end
         end
      end
      err = bad || ovf || (nd == 0) || (n > MAX_LEN);
      lo  = m[31:0];
      val = err ? 32'd0 : (neg ? -lo : lo);
   endfunction

   // Drive one word, one character per accepted beat; optionally queue its result.
   task automatic send_word(input string s, input bit last_at_end, input bit push);
      logic e;
      logic [31:0] v;
      for (int i = 0; i < s.len(); i++) begin
         int waited = 0;
         bit took = 0;
         if ($urandom_range(0, 4) == 0) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            bus.i_char  = 8'($urandom);
            bus.i_last  = 1'($urandom_range(0, 1));
         end
         while (!took) begin
            @(negedge clk);
            bus.i_valid = 1'b1;
            bus.i_char  = s[i];
            bus.i_last  = last_at_end && (i == s.len() - 1);
            took = bus.o_ready;
            @(posedge clk);
            if (!took) begin
               waited++;
               if (waited > 60) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL ready_timeout: got o_ready=0 for %0d cycles expected 1", waited);
                  #1 bus.i_valid = 1'b0;
                  return;
               end
            end
         end
      end
      if (push) begin
         model(s, e, v);
         exp_q.push_back({e, v});
      end
      #1;
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
   endtask

   function automatic string rand_word();
      string s = "";
      string hexc = "0123456789abcdefABCDEF";
      string mix  = "-0123456789abxXBG ";
      string edges[14] = '{"-", "0", "-0", "0x", "0b", "-0x", "-0b", "00", "0x0",
                           "4294967295", "4294967296", "-2147483648", "-2147483649", "2147483647"};
      int k = $urandom_range(0, 7);
      int n;
      longint base;
      int off;
      case (k)
         0: begin
            if ($urandom_range(0, 1) == 1) s = "-";
            n = $urandom_range(1, 11);
            repeat (n) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
         end
         1: begin
            if ($urandom_range(0, 1) == 1) s = "-";
            if ($urandom_range(0, 1) == 1) s = {s, "0x"}; else s = {s, "0X"};
            n = $urandom_range(1, 9);
            repeat (n) s = $sformatf("%s%c", s, hexc[$urandom_range(0, 21)]);
         end
         2: begin
            if ($urandom_range(0, 1) == 1) s = "-";
            if ($urandom_range(0, 1) == 1) s = {s, "0b"}; else s = {s, "0B"};
            n = $urandom_range(1, 34);
            repeat (n) s = $sformatf("%s%0d", s, $urandom_range(0, 1));
         end
         3: begin
            n = $urandom_range(1, 8);
            repeat (n) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
            s.putc($urandom_range(0, n - 1), mix[$urandom_range(0, 17)]);
         end
         4: begin
            n = $urandom_range(28, 36);
            repeat (n - 1) s = {s, "0"};
            s = $sformatf("%s%0d", s, $urandom_range(1, 9));
         end
         5: s = edges[$urandom_range(0, 13)];
         6: begin
            n = $urandom_range(1, 5);
            repeat (n) s = $sformatf("%s%c", s, mix[$urandom_range(0, 17)]);
         end
         default: begin
            base = ($urandom_range(0, 1) == 1) ? 64'd4294967295 : 64'd2147483648;
            off  = $urandom_range(0, 6) - 3;
            s = $sformatf("%s%0d", ($urandom_range(0, 1) == 1) ? "-" : "", base + longint'(off));
         end
      endcase
      return s;
   endfunction

   // Output checker and result consumer, once per cycle away from the clock edge.
   initial begin
      bus.i_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("o_ready", 64'(bus.o_ready), 64'(!bus.o_valid));
            if (exp_q.size() > 0) begin
               check("o_valid", 64'(bus.o_valid), 64'd1);
               if (bus.o_valid) begin
                  check("o_data", 64'(bus.o_data), 64'(exp_q[0][31:0]));
                  check("o_err", 64'(bus.o_err), 64'(exp_q[0][32]));
               end
            end else if (bus.o_valid) begin
               check("spurious_valid", 64'(bus.o_valid), 64'd0);
            end
            if (bus.o_valid) begin
               if (hold_cnt > 0) begin
                  bus.i_ready = 1'b0;
                  hold_cnt--;
               end else begin
                  bus.i_ready = ($urandom_range(0, 3) != 0);
               end
               if (bus.i_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
               bus.i_ready = 1'($urandom_range(0, 1));
            end
         end else begin
            bus.i_ready = 1'b0;
         end
      end
   end

   initial begin
      string pin_s[15] = '{"0x1F", "-42", "0b101", "0", "0xFFFFFFFF", "0x100000000",
                           "-2147483648", "-2147483649", "0b1012", "0x", "-", "12G", "7",
                           "-0", "000000000000000000000000000000007"};
      logic [32:0] pin_e[15] = '{{1'b0, 32'h0000001F}, {1'b0, 32'hFFFFFFD6}, {1'b0, 32'h00000005},
                                 {1'b0, 32'h0}, {1'b0, 32'hFFFFFFFF}, {1'b1, 32'h0},
                                 {1'b0, 32'h80000000}, {1'b1, 32'h0}, {1'b1, 32'h0},
                                 {1'b1, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0},
                                 {1'b0, 32'h00000007}, {1'b0, 32'h0}, {1'b1, 32'h0}};
      logic e;
      logic [31:0] v;
      int guard;

      rst_n = 1'b0;
      bus.i_abort = 1'b0;
      bus.i_valid = 1'b1;
      bus.i_char  = "5";
      bus.i_last  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_o_valid", 64'(bus.o_valid), 64'd0);
         check("rst_o_ready", 64'(bus.o_ready), 64'd1);
         check("rst_o_data", 64'(bus.o_data), 64'd0);
         check("rst_o_err", 64'(bus.o_err), 64'd0);
      end
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
      rst_n = 1'b1;
      chk_en = 1;

      // Pin the reference parser with hand-computed results, then run the same words.
      for (int i = 0; i < 15; i++) begin
         model(pin_s[i], e, v);
         check($sformatf("model[%s]", pin_s[i]), 64'({e, v}), 64'(pin_e[i]));
      end
      for (int i = 0; i < 15; i++) send_word(pin_s[i], 1'b1, 1'b1);

      // Consumer stalls for 5 cycles while the next word's first character waits.
      hold_cnt = 5;
      send_word("-42", 1'b1, 1'b1);
      send_word("0b101", 1'b1, 1'b1);

      // Abort mid-word, with a competing last beat in the same cycle.
      send_word("12", 1'b0, 1'b0);
      @(negedge clk);
      bus.i_abort = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_char  = "9";
      bus.i_last  = 1'b1;
      @(negedge clk);
      bus.i_abort = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
      send_word("3", 1'b1, 1'b1);

      // Reset in the middle of a word.
      send_word("0x1", 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_o_valid", 64'(bus.o_valid), 64'd0);
      check("midrst_o_ready", 64'(bus.o_ready), 64'd1);
      check("midrst_o_data", 64'(bus.o_data), 64'd0);
      rst_n = 1'b1;
      send_word("7", 1'b1, 1'b1);

      repeat (300) send_word(rand_word(), 1'b1, 1'b1);

      guard = 0;
      while (exp_q.size() > 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/word_to_number.md
WORD_TO_NUMBER -- requirements
Module: word_to_number

Interface
REQ-001 SHALL have parameter DATA, default 32, result width in bits (legal 8..64).
REQ-002 SHALL have parameter MAX_LEN, default 32, maximum characters per word including sign and prefix.
REQ-003 SHALL have parameter DEF_RADIX, default 10, radix for unprefixed words (legal 10 or 16).
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_abort  input  1  synchronous discard of the word in progress.
REQ-007 SHALL have port i_valid  input  1  character present on i_char.
REQ-008 SHALL have port i_char  input  8  ASCII character.
REQ-009 SHALL have port i_last  input  1  i_char is the final character of the word.
REQ-010 SHALL have port o_ready  output  1  module accepts a character this cycle.
REQ-011 SHALL have port o_valid  output  1  result present on o_data/o_err.
REQ-012 SHALL have port i_ready  input  1  consumer takes the result.
REQ-013 SHALL have port o_data  output  DATA  parsed value, two's complement.
REQ-014 SHALL have port o_err  output  1  word is not a valid number.

Function
REQ-015 SHALL accept a character only when i_valid and o_ready are both high (beat); o_ready SHALL equal NOT o_valid.
REQ-016 SHALL process exactly one character per beat with no stall cycles.
REQ-017 SHALL use FSM states START, SIGN, ZERO, DIGITS, SKIP, DONE.
REQ-018 START: '-' -> SIGN with neg=1; '0' -> ZERO; other digit valid in DEF_RADIX -> DIGITS; any other character -> SKIP with err.
REQ-019 SIGN: '0' -> ZERO; digit valid in DEF_RADIX -> DIGITS; otherwise SKIP with err.
REQ-020 ZERO: 'x'/'X' -> DIGITS in radix 16; 'b'/'B' -> DIGITS in radix 2; digit valid in DEF_RADIX -> DIGITS in DEF_RADIX; otherwise SKIP with err.
REQ-021 DIGITS: digit valid in current radix -> acc = acc*radix + digit; otherwise SKIP with err.
REQ-022 Hex digits SHALL be 0-9, A-F, a-f; binary 0-1; decimal 0-9.
REQ-023 acc SHALL be DATA+4 bits wide; ×2 and ×16 SHALL be implemented as shifts, ×10 as (acc<<3)+(acc<<1).
REQ-024 A sticky overflow flag SHALL set when the unsigned magnitude exceeds 2^DATA-1 (neg=0) or 2^(DATA-1) (neg=1); acc SHALL saturate once overflow is set.
REQ-025 A sticky length error SHALL set when a word exceeds MAX_LEN characters.
REQ-026 SKIP SHALL consume characters without updating acc until i_last.
REQ-027 On the beat with i_last, the FSM SHALL enter DONE from any state; o_valid SHALL be high on the following cycle (latency 1 from the last beat).
REQ-028 Words ending in START-equivalent positions SHALL be errors: a single '-', "0x", "0b", "-0x", "-0b".
REQ-029 A word consisting solely of "0" or "-0" SHALL yield 0 with o_err=0.
REQ-030 In DONE with no error: o_data = neg ? -(acc[DATA-1:0]) : acc[DATA-1:0], o_err=0.
REQ-031 In DONE with any error (invalid character, overflow, length, empty digits): o_data=0, o_err=1.
REQ-032 o_valid, o_data and o_err SHALL hold stable until i_ready is high; the FSM SHALL then return to START on the next cycle and clear acc, neg, radix and error flags.
REQ-033 i_abort SHALL force START, clear all internal state and o_valid on the next edge, and take priority over a simultaneous beat or output handshake.
REQ-034 i_valid with o_ready low SHALL be ignored and produce no state change.

Reset
REQ-035 While i_rst_n is low, SHALL hold state START, acc=0, neg=0, and o_valid=0, o_data=0, o_err=0, o_ready=1.
REQ-036 Reset asserted mid-word SHALL discard the word; the first beat after release SHALL be treated as a first character.

Verification
REQ-037 DATA=32: "0x1F" then i_ready=1 -> one cycle after the last beat, o_valid=1, o_data=0x0000001F, o_err=0; o_ready returns high after the handshake.
REQ-038 "-42" -> o_data=0xFFFFFFD6, o_err=0; "0b101" -> 0x00000005; "0" -> 0x00000000, o_err=0.
REQ-039 "0xFFFFFFFF" -> 0xFFFFFFFF, o_err=0; "0x100000000" -> o_data=0, o_err=1; "-2147483648" -> 0x80000000; "-2147483649" -> o_err=1.
REQ-040 "0b1012", "0x", "-", and "12G" -> o_data=0, o_err=1, each after its own last beat; the next word "7" -> 0x00000007.
REQ-041 Hold i_ready=0 for 5 cycles with i_valid=1 -> o_data stable, o_ready=0, and no characters consumed.
REQ-042 Reset asserted after "0x1", then "7" with i_last -> 0x00000007; i_abort after "12", then "3" -> 0x00000003.
